// File: rtl/zjh_scan_seq_138_pkg.sv
// Shared decoder enable codes and scan FSM state type for the 74HC138 scan controller.
// Pure declarations: no latency, no handshake.
package zjh_scan_pkg;

  localparam logic [2:0] E_ON  = 3'b100;
  localparam logic [2:0] E_OFF = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

endpackage

// File: rtl/zjh_scan_seq_138_if.sv
// Scan controller bus: run controls in, decoder select/enable and status out.
// Optional manual-step pins exist only when ZJH_SCAN_MANUAL_EN is defined.
interface zjh_scan_seq_138_if;
  logic       en;
  logic [7:0] ch_mask;
  logic [2:0] A;
  logic [2:0] E;
  logic       ch_active;
  logic       frame_start;
`ifdef ZJH_SCAN_MANUAL_EN
  logic       manual;
  logic       step;

  modport master (output en, ch_mask, manual, step,
                  input  A, E, ch_active, frame_start);
  modport slave  (input  en, ch_mask, manual, step,
                  output A, E, ch_active, frame_start);
`else
  modport master (output en, ch_mask,
                  input  A, E, ch_active, frame_start);
  modport slave  (input  en, ch_mask,
                  output A, E, ch_active, frame_start);
`endif
endinterface

// File: rtl/zjh_scan_seq_138_next_ch.sv
// Circular priority finder: first set mask bit strictly above cur, wrapping 7->0.
// Combinational, zero latency; wrap flags a selection at or below cur.
module zjh_next_ch (
  input  logic [2:0] cur,
  input  logic [7:0] mask,
  output logic [2:0] nxt,
  output logic       wrap,
  output logic       none
);

  logic       found;
  logic [2:0] idx;

  // i==8 lands back on cur, so a lone set bit selects itself.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign none = ~|mask;
  assign wrap = (nxt <= cur);

endmodule

// File: rtl/zjh_scan_seq_138.sv
// Round-robin 74HC138 scan controller with blank-before-drive slots; all outputs registered, 1-cycle input-to-output.
// No backpressure; optional manual stepping under ZJH_SCAN_MANUAL_EN.
module zjh_scan_seq_138
  import zjh_scan_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  zjh_scan_seq_138_if.slave bus
);

  localparam int              CW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   BLANK_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0]   DRIVE_FIRST = CW'(BLANK_CYC);
  localparam logic [CW-1:0]   SLOT_LAST   = CW'(CLK_DIV - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    a_q;
  logic [2:0]    e_q;
  logic          act_q;
  logic          fs_q;

  logic [2:0]    cur;
  logic [2:0]    nxt;
  logic          wrap;
  logic          none;
  logic          slot_end;
  logic          hold;

  // From IDLE, searching above channel 7 yields the lowest set bit.
  assign cur = (state == IDLE) ? 3'd7 : a_q;

  zjh_next_ch u_next_ch (
    .cur  (cur),
    .mask (bus.ch_mask),
    .nxt  (nxt),
    .wrap (wrap),
    .none (none)
  );

`ifdef ZJH_SCAN_MANUAL_EN
  assign slot_end = bus.manual ? bus.step : (cnt == SLOT_LAST);
  assign hold     = bus.manual & ~bus.step;
`else
  assign slot_end = (cnt == SLOT_LAST);
  assign hold     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= 3'b000;
      e_q   <= E_OFF;
      act_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      if (!bus.en) begin
        state <= IDLE;
        cnt   <= '0;
        e_q   <= E_OFF;
        act_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!none) begin
              state <= BLANK;
              a_q   <= nxt;
              cnt   <= '0;
              fs_q  <= 1'b1;
              e_q   <= E_OFF;
            end
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_LAST) begin
              state <= DRIVE;
              e_q   <= E_ON;
              act_q <= 1'b1;
            end
          end
          DRIVE: begin
            if (slot_end) begin
              // A only moves on the edge that also turns the decoder off.
              cnt   <= '0;
              e_q   <= E_OFF;
              act_q <= 1'b0;
              if (none) begin
                state <= IDLE;
              end else begin
                state <= BLANK;
                a_q   <= nxt;
                fs_q  <= wrap;
              end
            end else if (hold) begin
              cnt <= DRIVE_FIRST;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            e_q   <= E_OFF;
            act_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.A           = a_q;
  assign bus.E           = e_q;
  assign bus.ch_active   = act_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_zjh_scan_seq_138.sv
// Randomised scoreboard bench for zjh_scan_seq_138 against a slot-position reference model.
module tb_zjh_scan_seq_138;

  localparam int         CLK_DIV   = 16;
  localparam int         BLANK_CYC = 2;
  localparam logic [2:0] EON       = 3'b100;
  localparam logic [2:0] EOFF      = 3'b011;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] e;
    logic       act;
    logic       fs;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zjh_scan_seq_138_if bus ();

  zjh_scan_seq_138 #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  // Reference model: running flag, current channel, position within the slot.
  bit run = 1'b0;
  int ch  = 0;
  int pos = 0;

  logic       prev_valid = 1'b0;
  logic [2:0] prev_a;
  logic [2:0] prev_e;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic int lowest_set(input logic [7:0] m);
    for (int j = 0; j < 8; j++) if (m[j]) return j;
    return 0;
  endfunction

  function automatic int next_above(input int c, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) if (m[(c + k) % 8]) return (c + k) % 8;
    return c;
  endfunction

  function automatic exp_t model_edge();
    exp_t r;
    bit   fs  = 1'b0;
    bit   man = 1'b0;
    bit   stp = 1'b0;
    bit   drive;
    bit   boundary;
`ifdef ZJH_SCAN_MANUAL_EN
    man = bus.manual;
    stp = bus.step;
`endif
    if (!bus.en) begin
      run = 1'b0;
      pos = 0;
    end else if (!run) begin
      if (bus.ch_mask != 8'h00) begin
        run = 1'b1;
        ch  = lowest_set(bus.ch_mask);
        pos = 0;
        fs  = 1'b1;
      end
    end else begin
      drive    = (pos >= BLANK_CYC);
      boundary = drive && (man ? stp : (pos == CLK_DIV - 1));
      if (boundary) begin
        pos = 0;
        if (bus.ch_mask == 8'h00) begin
          run = 1'b0;
        end else begin
          int n;
          n  = next_above(ch, bus.ch_mask);
          fs = (n <= ch);
          ch = n;
        end
      end else if (drive && man) begin
        pos = BLANK_CYC;
      end else begin
        pos++;
      end
    end
    r.a   = 3'(ch);
    r.act = run && (pos >= BLANK_CYC);
    r.e   = r.act ? EON : EOFF;
    r.fs  = fs;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) sb_q.push_back(model_edge());
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_A"},  {5'd0, bus.A}, 8'h00);
    check({tag, "_E"},  {5'd0, bus.E}, {5'd0, EOFF});
    check({tag, "_ch_active"},   {7'd0, bus.ch_active},   8'h00);
    check({tag, "_frame_start"}, {7'd0, bus.frame_start}, 8'h00);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("A",           {5'd0, bus.A},           {5'd0, x.a});
      check("E",           {5'd0, bus.E},           {5'd0, x.e});
      check("ch_active",   {7'd0, bus.ch_active},   {7'd0, x.act});
      check("frame_start", {7'd0, bus.frame_start}, {7'd0, x.fs});
      if (prev_valid && prev_e == EON && bus.E == EON)
        check("a_stable_while_on", {5'd0, bus.A}, {5'd0, prev_a});
      prev_a     = bus.A;
      prev_e     = bus.E;
      prev_valid = 1'b1;
    end
  end

  initial begin
    bus.en      = 1'b0;
    bus.ch_mask = 8'hFF;
`ifdef ZJH_SCAN_MANUAL_EN
    bus.manual  = 1'b0;
    bus.step    = 1'b0;
`endif
    #12;
    check_reset_values("reset");

    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.en = 1'b1;

    // Full mask: 0..7 round robin, frame every 128 cycles.
    repeat (300) tick();

    // Sparse mask 2,5,7.
    bus.ch_mask = 8'b1010_0100;
    repeat (200) tick();

    // Full mask, then collapse to channel 0 mid-slot.
    bus.ch_mask = 8'hFF;
    repeat (60) tick();
    bus.ch_mask = 8'h01;
    repeat (100) tick();

    // Channel 4 only; drop en while driving, then re-raise.
    bus.ch_mask = 8'h10;
    repeat (40) tick();
    repeat (5) tick();
    bus.en = 1'b0;
    repeat (3) tick();
    bus.ch_mask = 8'h24;
    bus.en = 1'b1;
    repeat (40) tick();

    // Random traffic: rare en drops, occasional mask changes including empty.
    for (int n = 0; n < 3000; n++) begin
      tick();
      bus.en = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 39) == 0)
        bus.ch_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    end

`ifdef ZJH_SCAN_MANUAL_EN
    // Manual stepping with sporadic step pulses.
    bus.en      = 1'b1;
    bus.ch_mask = 8'hFF;
    bus.manual  = 1'b1;
    for (int n = 0; n < 600; n++) begin
      tick();
      bus.step = ($urandom_range(0, 24) == 0);
    end
    bus.step   = 1'b0;
    bus.manual = 1'b0;
`endif

    // Empty mask with en high stays idle.
    bus.en      = 1'b1;
    bus.ch_mask = 8'h00;
    repeat (50) tick();

    // Async reset while driving channel 4.
    bus.ch_mask = 8'h10;
    repeat (6) tick();
    @(negedge clk);
    check("pre_reset_A", {5'd0, bus.A}, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    run = 1'b0;
    ch  = 0;
    pos = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int n = 0; n < 200; n++) begin
      tick();
      if ($urandom_range(0, 29) == 0) bus.ch_mask = 8'($urandom_range(0, 255));
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 8'(sb_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
